// File: rtl/op_stack.sv
// Operand stack with single-cycle PUSH/POP/DUP/SWAP/REPL/OVER/CLEAR,
// exposing TOS/NOS, fill level and sticky overflow/underflow flags.
module op_stack #(
  parameter int MSB  = 7,
  parameter int AMSB = 3
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic            setb,
  input  logic [2:0]      op,
  input  logic [MSB:0]    wdata,
  input  logic            clr_err,
  output logic [MSB:0]    rdata,
  output logic [MSB:0]    nos,
  output logic [AMSB+1:0] cnt,
  output logic            empty,
  output logic            full,
  output logic            ovf,
  output logic            udf
);

  localparam int CW = AMSB + 2;
  localparam int D  = 1 << (AMSB + 1);
  localparam logic [CW-1:0] DCNT = CW'(D);

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_POP   = 3'd2;
  localparam logic [2:0] OP_DUP   = 3'd3;
  localparam logic [2:0] OP_SWAP  = 3'd4;
  localparam logic [2:0] OP_REPL  = 3'd5;
  localparam logic [2:0] OP_OVER  = 3'd6;
  localparam logic [2:0] OP_CLEAR = 3'd7;

  logic [MSB:0]  mem_q [D];
  logic [MSB:0]  mem_d [D];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic [CW-1:0] tos_ptr_s, nos_ptr_s;
  logic [AMSB:0] tos_idx_s, nos_idx_s, top_idx_s;
  logic [MSB:0]  tos_s, nos_s;
  logic [CW-1:0] req_depth_s;
  logic          req_space_s;
  logic          full_s, short_depth_s, short_space_s;

  assign tos_ptr_s = cnt_q - CW'(1);
  assign nos_ptr_s = cnt_q - CW'(2);
  assign tos_idx_s = tos_ptr_s[AMSB:0];
  assign nos_idx_s = nos_ptr_s[AMSB:0];
  // Free slot index; only used when not full, so the wrap at cnt==D is harmless.
  assign top_idx_s = cnt_q[AMSB:0];
  assign tos_s     = (cnt_q >= CW'(1)) ? mem_q[tos_idx_s] : '0;
  assign nos_s     = (cnt_q >= CW'(2)) ? mem_q[nos_idx_s] : '0;
  assign full_s    = (cnt_q == DCNT);

  // Per-op requirements: entries that must already be present, and whether a free slot is needed.
  always_comb begin
    req_depth_s = CW'(0);
    req_space_s = 1'b0;
    case (op)
      OP_PUSH: begin req_depth_s = CW'(0); req_space_s = 1'b1; end
      OP_POP:  begin req_depth_s = CW'(1); req_space_s = 1'b0; end
      OP_DUP:  begin req_depth_s = CW'(1); req_space_s = 1'b1; end
      OP_SWAP: begin req_depth_s = CW'(2); req_space_s = 1'b0; end
      OP_REPL: begin req_depth_s = CW'(1); req_space_s = 1'b0; end
      OP_OVER: begin req_depth_s = CW'(2); req_space_s = 1'b1; end
      default: begin req_depth_s = CW'(0); req_space_s = 1'b0; end
    endcase
  end

  assign short_depth_s = (cnt_q < req_depth_s);
  assign short_space_s = req_space_s & full_s;

  // Next-state: depth shortfall wins over space shortfall; failing ops touch only the flags.
  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (setb) begin
      if (clr_err) begin
        ovf_d = 1'b0;
        udf_d = 1'b0;
      end else begin
        ovf_d = ovf_q;
        udf_d = udf_q;
      end
      if (short_depth_s) begin
        udf_d = 1'b1;
      end else if (short_space_s) begin
        ovf_d = 1'b1;
      end else begin
        case (op)
          OP_NOP: cnt_d = cnt_q;
          OP_PUSH: begin
            mem_d[top_idx_s] = wdata;
            cnt_d = cnt_q + CW'(1);
          end
          OP_POP: cnt_d = cnt_q - CW'(1);
          OP_DUP: begin
            mem_d[top_idx_s] = tos_s;
            cnt_d = cnt_q + CW'(1);
          end
          OP_SWAP: begin
            mem_d[tos_idx_s] = nos_s;
            mem_d[nos_idx_s] = tos_s;
          end
          OP_REPL: mem_d[tos_idx_s] = wdata;
          OP_OVER: begin
            mem_d[top_idx_s] = nos_s;
            cnt_d = cnt_q + CW'(1);
          end
          OP_CLEAR: cnt_d = CW'(0);
          default: cnt_d = cnt_q;
        endcase
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cnt_q <= CW'(0);
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = tos_s;
  assign nos   = nos_s;
  assign cnt   = cnt_q;
  assign empty = (cnt_q == CW'(0));
  assign full  = full_s;
  assign ovf   = ovf_q;
  assign udf   = udf_q;

endmodule

// File: tb/tb_op_stack.sv
// Directed self-checking bench for op_stack (D = 16, 8-bit words).
module tb_op_stack;

  logic       clk;
  logic       rstb;
  logic       setb;
  logic [2:0] op;
  logic [7:0] wdata;
  logic       clr_err;
  logic [7:0] rdata;
  logic [7:0] nos;
  logic [4:0] cnt;
  logic       empty;
  logic       full;
  logic       ovf;
  logic       udf;

  int total = 0;
  int bad   = 0;

  op_stack #(.MSB(7), .AMSB(3)) dut (
    .clk(clk), .rstb(rstb), .setb(setb), .op(op), .wdata(wdata),
    .clr_err(clr_err), .rdata(rdata), .nos(nos), .cnt(cnt),
    .empty(empty), .full(full), .ovf(ovf), .udf(udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one op on the next posedge, then settle just after it.
  task automatic step(input logic [2:0] o, input logic [7:0] w, input logic ce, input logic en);
    op = o; wdata = w; clr_err = ce; setb = en;
    @(posedge clk);
    #1;
    op = 3'd0; clr_err = 1'b0; setb = 1'b1;
  endtask

  task automatic fill16();
    for (int i = 1; i <= 16; i++) step(3'd1, 8'(i), 1'b0, 1'b1);
  endtask

  initial begin
    rstb = 1'b0; setb = 1'b1; op = 3'd0; wdata = 8'h00; clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_cnt", cnt, 0);
    check_val("rst_empty", empty, 1);
    check_val("rst_full", full, 0);
    check_val("rst_rdata", rdata, 0);
    check_val("rst_nos", nos, 0);
    check_val("rst_ovf", ovf, 0);
    check_val("rst_udf", udf, 0);
    rstb = 1'b1;
    step(3'd0, 8'h00, 1'b0, 1'b1);
    check_val("idle_cnt", cnt, 0);
    check_val("idle_empty", empty, 1);

    // Fill and overflow
    fill16();
    check_val("fill_full", full, 1);
    check_val("fill_empty", empty, 0);
    check_val("fill_cnt", cnt, 16);
    check_val("fill_rdata", rdata, 8'h10);
    check_val("fill_nos", nos, 8'h0F);
    step(3'd1, 8'hAA, 1'b0, 1'b1);
    check_val("ovf_flag", ovf, 1);
    check_val("ovf_udf", udf, 0);
    check_val("ovf_rdata", rdata, 8'h10);
    check_val("ovf_cnt", cnt, 16);
    step(3'd3, 8'h00, 1'b0, 1'b1);
    check_val("dup_full_ovf", ovf, 1);
    check_val("dup_full_cnt", cnt, 16);
    check_val("dup_full_rdata", rdata, 8'h10);
    step(3'd7, 8'h00, 1'b0, 1'b1);
    check_val("clear_cnt", cnt, 0);
    check_val("clear_ovf_kept", ovf, 1);
    step(3'd0, 8'h00, 1'b1, 1'b1);
    check_val("clr_ovf", ovf, 0);

    // Stack ops
    step(3'd1, 8'h11, 1'b0, 1'b1);
    step(3'd1, 8'h22, 1'b0, 1'b1);
    check_val("push2_rdata", rdata, 8'h22);
    check_val("push2_nos", nos, 8'h11);
    step(3'd4, 8'h00, 1'b0, 1'b1);
    check_val("swap_rdata", rdata, 8'h11);
    check_val("swap_nos", nos, 8'h22);
    step(3'd6, 8'h00, 1'b0, 1'b1);
    check_val("over_rdata", rdata, 8'h22);
    check_val("over_nos", nos, 8'h11);
    check_val("over_cnt", cnt, 3);
    step(3'd3, 8'h00, 1'b0, 1'b1);
    check_val("dup_cnt", cnt, 4);
    check_val("dup_rdata", rdata, 8'h22);
    check_val("dup_nos", nos, 8'h22);
    step(3'd5, 8'h5A, 1'b0, 1'b1);
    check_val("repl_rdata", rdata, 8'h5A);
    check_val("repl_nos", nos, 8'h22);
    check_val("repl_cnt", cnt, 4);
    step(3'd2, 8'h00, 1'b0, 1'b1);
    check_val("pop_rdata", rdata, 8'h22);
    check_val("pop_cnt", cnt, 3);

    // Underflow
    step(3'd7, 8'h00, 1'b0, 1'b1);
    step(3'd2, 8'h00, 1'b0, 1'b1);
    check_val("udf_flag", udf, 1);
    check_val("udf_ovf", ovf, 0);
    check_val("udf_cnt", cnt, 0);
    step(3'd1, 8'h33, 1'b0, 1'b1);
    step(3'd4, 8'h00, 1'b0, 1'b1);
    check_val("swap1_udf", udf, 1);
    check_val("swap1_rdata", rdata, 8'h33);
    check_val("swap1_nos", nos, 8'h00);
    check_val("swap1_cnt", cnt, 1);
    step(3'd0, 8'h00, 1'b1, 1'b1);
    check_val("clr_udf", udf, 0);
    check_val("clr_ovf2", ovf, 0);

    // Simultaneous error and clear; disabled block
    step(3'd7, 8'h00, 1'b0, 1'b1);
    step(3'd2, 8'h00, 1'b0, 1'b1);
    fill16();
    step(3'd1, 8'hAA, 1'b0, 1'b1);
    step(3'd7, 8'h00, 1'b0, 1'b1);
    check_val("both_ovf", ovf, 1);
    check_val("both_udf", udf, 1);
    step(3'd2, 8'h00, 1'b1, 1'b1);
    check_val("sim_udf", udf, 1);
    check_val("sim_ovf", ovf, 0);
    check_val("sim_cnt", cnt, 0);
    step(3'd1, 8'h77, 1'b1, 1'b0);
    check_val("dis_cnt", cnt, 0);
    check_val("dis_udf", udf, 1);
    check_val("dis_ovf", ovf, 0);
    check_val("dis_rdata", rdata, 8'h00);

    // Async reset mid-sequence
    for (int i = 0; i < 5; i++) step(3'd1, 8'(8'h60 + i), 1'b0, 1'b1);
    check_val("pre_rst_cnt", cnt, 5);
    check_val("pre_rst_rdata", rdata, 8'h64);
    #2;
    rstb = 1'b0;
    #1;
    check_val("async_cnt", cnt, 0);
    check_val("async_rdata", rdata, 8'h00);
    check_val("async_udf", udf, 0);
    #1;
    rstb = 1'b1;
    step(3'd1, 8'h44, 1'b0, 1'b1);
    check_val("post_rst_cnt", cnt, 1);
    check_val("post_rst_rdata", rdata, 8'h44);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
